// File: rtl/r22sdf_frame_ctrl.sv
// Frame sequencer for an R22SDF FFT pipeline: gates the FFT enable, inserts zero
// bubbles to drain the tail of the last frame, and tags results with bin order.
module r22sdf_frame_ctrl #(
  parameter int FFT_LEN = 16,
  parameter int LAT     = 15,
  parameter int IDX_W   = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             cordic_rdy,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic             fft_en,
  output logic             fft_bubble,
  input  logic             m_ready,
  output logic             m_valid,
  output logic             m_sof,
  output logic             m_eof,
  output logic [IDX_W-1:0] m_idx,
  output logic             err_len
);

  // state    | meaning
  // WAIT_RDY | twiddle generators not ready yet; nothing moves
  // RUN      | accepting samples, FFT advances per accepted sample
  // FLUSH    | frame complete; zero bubbles push remaining results out
  typedef enum logic [1:0] {WAIT_RDY, RUN, FLUSH} state_t;

  localparam int SW = $clog2(LAT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FFT_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
  localparam logic [SW-1:0]    SINCE_MAX   = SW'(LAT);
  localparam logic [SW-1:0]    SINCE_EARLY = SW'(LAT - 1);
  localparam logic [SW-1:0]    SINCE_ONE   = SW'(1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] in_cnt_q, in_cnt_d;
  logic [IDX_W-1:0] out_cnt_q, out_cnt_d;
  logic [LAT-1:0]   tag_q, tag_d;
  logic [LAT:0]     tag_shift;
  logic [SW-1:0]    since_q, since_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             stall, halt, accept, flush_now, early_exit;

  assign m_valid = tag_q[LAT-1];
  assign stall   = m_valid & ~m_ready;
  assign halt    = ~cordic_rdy;
  assign accept  = s_valid & s_ready;
  // Cycle after a frame end with no follow-on sample: start bubbling at once so
  // the output keeps advancing instead of re-presenting the same result.
  assign flush_now  = (state_q == RUN) & done_q & ~s_valid;
  assign early_exit = s_valid & fft_en & (since_q >= SINCE_EARLY);

  always_comb begin
    s_ready    = 1'b0;
    fft_en     = 1'b0;
    fft_bubble = 1'b0;
    case (state_q)
      RUN: begin
        if (flush_now) begin
          fft_bubble = 1'b1;
          fft_en     = ~stall & ~halt;
        end else begin
          s_ready = ~stall & ~halt;
          fft_en  = s_valid & ~stall & ~halt;
        end
      end
      FLUSH: begin
        fft_bubble = 1'b1;
        fft_en     = ~stall & ~halt;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    in_cnt_d  = in_cnt_q;
    err_d     = 1'b0;
    out_cnt_d = out_cnt_q;
    since_d   = since_q;
    tag_shift = {tag_q, accept};
    tag_d     = fft_en ? tag_shift[LAT-1:0] : tag_q;

    case (state_q)
      WAIT_RDY: if (cordic_rdy) state_d = RUN;
      RUN: begin
        if (done_q && !halt) begin
          done_d = 1'b0;
          if (!s_valid) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!halt && ((tag_q == '0) || early_exit)) state_d = RUN;
      end
      default: state_d = WAIT_RDY;
    endcase

    if (accept) begin
      if (s_last && (in_cnt_q == LAST_IDX)) begin
        done_d   = 1'b1;
        in_cnt_d = '0;
      end else if (s_last || (in_cnt_q == LAST_IDX)) begin
        err_d    = 1'b1;
        in_cnt_d = '0;
      end else begin
        in_cnt_d = in_cnt_q + IDX_ONE;
      end
    end

    if (accept)
      since_d = '0;
    else if (fft_en && (since_q != SINCE_MAX))
      since_d = since_q + SINCE_ONE;

    if (m_valid && m_ready && !halt)
      out_cnt_d = out_cnt_q + IDX_ONE;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= WAIT_RDY;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      tag_q     <= '0;
      since_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      tag_q     <= tag_d;
      since_q   <= since_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign m_sof   = m_valid & (out_cnt_q == '0);
  assign m_eof   = m_valid & (out_cnt_q == LAST_IDX);
  assign err_len = err_q;

  always_comb begin
    m_idx = '0;
    for (int i = 0; i < IDX_W; i++) m_idx[i] = out_cnt_q[IDX_W-1-i];
  end

endmodule

// File: tb/tb_r22sdf_frame_ctrl.sv
// Directed bench for r22sdf_frame_ctrl; a scoreboard queue holds the expected
// frame position of every accepted sample and is checked as results leave.
module tb_r22sdf_frame_ctrl;
  localparam int FFT_LEN = 16;
  localparam int LAT     = 15;
  localparam int IDX_W   = 4;

  logic sys_clk = 1'b0;
  logic sys_rst, cordic_rdy, s_valid, s_last, m_ready;
  logic s_ready, fft_en, fft_bubble, m_valid, m_sof, m_eof, err_len;
  logic [IDX_W-1:0] m_idx;

  r22sdf_frame_ctrl #(.FFT_LEN(FFT_LEN), .LAT(LAT), .IDX_W(IDX_W)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cordic_rdy(cordic_rdy),
    .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .fft_en(fft_en), .fft_bubble(fft_bubble), .m_ready(m_ready),
    .m_valid(m_valid), .m_sof(m_sof), .m_eof(m_eof), .m_idx(m_idx),
    .err_len(err_len)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0, n_err = 0;
  int exp_q[$];
  int pos, n_out, cyc, first_cyc, last_cyc, err_cnt, en_cnt;
  bit seen_valid, chk_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IDX_W-1:0] bitrev(input int v);
    logic [IDX_W-1:0] a, r;
    a = IDX_W'(v);
    for (int i = 0; i < IDX_W; i++) r[i] = a[IDX_W-1-i];
    return r;
  endfunction

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      cyc++;
      if (err_len) err_cnt++;
      if (m_valid && !seen_valid) begin
        seen_valid = 1'b1;
        chk("first_valid_lat", en_cnt, LAT);
      end
      if (fft_en) en_cnt++;
      if (s_valid && s_ready) begin
        exp_q.push_back(pos);
        pos = s_last ? 0 : (pos + 1) % FFT_LEN;
      end
      if (m_valid && m_ready) begin
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          int e;
          e = exp_q.pop_front();
          if (chk_out) begin
            chk("m_idx", m_idx, bitrev(e));
            chk("m_sof", m_sof, e == 0);
            chk("m_eof", m_eof, e == FFT_LEN - 1);
          end
        end
        if (n_out == 0) first_cyc = cyc;
        last_cyc = cyc;
        n_out++;
      end
    end
  end

  task automatic clear_model();
    exp_q.delete();
    pos = 0; n_out = 0; cyc = 0; first_cyc = 0; last_cyc = 0;
    err_cnt = 0; en_cnt = 0; seen_valid = 1'b0;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    clear_model();
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
  endtask

  task automatic wait_acc();
    int b;
    b = 0;
    @(negedge sys_clk);
    chk("bubble_in_run", fft_bubble, 0);
    while (!s_ready && b < 200) begin
      @(negedge sys_clk);
      b++;
    end
    if (!s_ready) chk("accept_timeout", s_ready, 1);
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input int n, input int short_last, input int stall_at, input int halt_at);
    int base;
    base = short_last + 1;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_last  = (i == short_last) || (i >= base && ((i - base) % FFT_LEN) == FFT_LEN - 1);
      if (i == halt_at) begin
        cordic_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge sys_clk);
          chk("halt_s_ready", s_ready, 0);
          chk("halt_fft_en", fft_en, 0);
          @(posedge sys_clk);
          #1;
        end
        cordic_rdy = 1'b1;
      end
      if (i == stall_at) begin
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge sys_clk);
          chk("stall_m_valid", m_valid, 1);
          chk("stall_s_ready", s_ready, 0);
          chk("stall_fft_en", fft_en, 0);
          if (exp_q.size() != 0) chk("stall_m_idx", m_idx, bitrev(exp_q[0]));
          @(posedge sys_clk);
          #1;
        end
        m_ready = 1'b1;
      end
      wait_acc();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic finish_frames(input int target);
    int b;
    b = 0;
    while (n_out < target && b < 300) begin
      @(negedge sys_clk);
      b++;
    end
    repeat (LAT + 4) @(negedge sys_clk);
    chk("result_count", n_out, target);
    chk("sb_empty", exp_q.size(), 0);
    chk("flush_exit_ready", s_ready, 1);
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    int vcnt;
    sys_rst = 1'b1; cordic_rdy = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    m_ready = 1'b1; chk_out = 1'b1;
    clear_model();
    @(negedge sys_clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_fft_en", fft_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_idx", m_idx, 0);
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;

    // cordic not ready: input is refused even with s_valid high
    s_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge sys_clk);
      chk("wait_s_ready", s_ready, 0);
      chk("wait_fft_en", fft_en, 0);
    end
    @(posedge sys_clk);
    #1 cordic_rdy = 1'b1; s_valid = 1'b0;
    @(negedge sys_clk);
    chk("rdy_lag_cycle0", s_ready, 0);
    @(posedge sys_clk);
    #1;
    @(negedge sys_clk);
    chk("rdy_lag_cycle1", s_ready, 1);
    @(posedge sys_clk);
    #1;

    // single frame, with a brief cordic dropout mid-frame
    send(16, -1, -1, 5);
    @(negedge sys_clk);
    chk("bubble_after_last", fft_bubble, 1);
    chk("flush_fft_en", fft_en, 1);
    @(posedge sys_clk);
    #1;
    finish_frames(16);
    chk("single_err_cnt", err_cnt, 0);

    // back-to-back frames: 32 contiguous results
    do_reset();
    send(32, -1, -1, -1);
    finish_frames(32);
    chk("b2b_contiguous", last_cyc - first_cyc, 31);
    chk("b2b_err_cnt", err_cnt, 0);

    // downstream stall in the middle of the second frame
    do_reset();
    send(32, -1, 20, -1);
    finish_frames(32);

    // short frame (s_last on sample 9), then a clean 16-sample frame
    do_reset();
    chk_out = 1'b0;
    send(25, 8, -1, -1);
    finish_frames(25);
    chk("short_err_cnt", err_cnt, 1);
    chk_out = 1'b1;

    // reset asserted during flush
    do_reset();
    send(16, -1, -1, -1);
    repeat (3) begin
      @(posedge sys_clk);
      #1;
    end
    @(negedge sys_clk);
    chk("in_flush_bubble", fft_bubble, 1);
    @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    clear_model();
    #1;
    chk("rst_flush_s_ready", s_ready, 0);
    chk("rst_flush_fft_en", fft_en, 0);
    chk("rst_flush_bubble", fft_bubble, 0);
    chk("rst_flush_m_valid", m_valid, 0);
    chk("rst_flush_m_sof", m_sof, 0);
    chk("rst_flush_m_eof", m_eof, 0);
    chk("rst_flush_err_len", err_len, 0);
    chk("rst_flush_m_idx", m_idx, 0);
    cordic_rdy = 1'b0;
    s_valid = 1'b1;
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      chk("post_rst_s_ready", s_ready, 0);
      chk("post_rst_fft_en", fft_en, 0);
      chk("post_rst_m_valid", m_valid, 0);
    end
    @(posedge sys_clk);
    #1 s_valid = 1'b0; cordic_rdy = 1'b1;
    @(negedge sys_clk);
    chk("post_rst_wait_rdy", s_ready, 0);
    @(posedge sys_clk);
    #1;
    @(negedge sys_clk);
    chk("post_rst_run", s_ready, 1);
    vcnt = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (m_valid) vcnt++;
    end
    chk("post_rst_no_valid", vcnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/r22sdf_frame_ctrl.md
R22SDF_FRAME_CTRL -- requirements
Module: r22sdf_frame_ctrl

Interface
REQ-001 The block SHALL have parameter FFT_LEN, default 16: points per frame (power of 4).
REQ-002 The block SHALL have parameter LAT, default 15: number of FFT enables from a sample entering the FFT to the matching result appearing; legal range 1..64.
REQ-003 The block SHALL have parameter IDX_W, default 4: log2(FFT_LEN).
REQ-004 The block SHALL have port sys_clk, input, 1: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port sys_rst, input, 1: asynchronous, active-high reset.
REQ-006 The block SHALL have port cordic_rdy, input, 1: FFT twiddle generators ready.
REQ-007 The block SHALL have port s_valid, input, 1: input sample valid.
REQ-008 The block SHALL have port s_last, input, 1: input sample is the last of its frame.
REQ-009 The block SHALL have port s_ready, output, 1: input sample accepted when s_valid & s_ready.
REQ-010 The block SHALL have port fft_en, output, 1: drives the FFT sys_en; the FFT pipeline advances only when it is 1.
REQ-011 The block SHALL have port fft_bubble, output, 1: selects zero on the FFT data inputs during flush.
REQ-012 The block SHALL have port m_ready, input, 1: downstream accepts a result.
REQ-013 The block SHALL have port m_valid, output, 1: FFT output holds a valid result.
REQ-014 The block SHALL have port m_sof, output, 1: result is bin-order position 0 of its frame.
REQ-015 The block SHALL have port m_eof, output, 1: result is position FFT_LEN-1 of its frame.
REQ-016 The block SHALL have port m_idx, output, IDX_W: natural-order bin number of the current result.
REQ-017 The block SHALL have port err_len, output, 1: one-cycle pulse on a frame-length violation.

Function
REQ-018 The block SHALL implement a state machine with states WAIT_RDY, RUN and FLUSH; the reset state SHALL be WAIT_RDY.
REQ-019 WAIT_RDY SHALL force s_ready=0 and fft_en=0, and SHALL move to RUN on the first cycle cordic_rdy=1.
REQ-020 The stall condition SHALL be defined as m_valid & !m_ready.
REQ-021 In RUN, s_ready SHALL equal !stall, and fft_en SHALL equal s_valid & s_ready; fft_bubble SHALL be 0.
REQ-022 A tag shift register of depth LAT SHALL shift on every fft_en, inserting 1 for an accepted sample and 0 for a bubble.
REQ-023 m_valid SHALL be the registered tag output; while stall is true, fft_en=0, so the FFT and the tags hold.
REQ-024 An input counter in_cnt (0..FFT_LEN-1) SHALL increment on each accepted sample and wrap to 0.
REQ-025 Accepting s_last with in_cnt=FFT_LEN-1 SHALL move RUN to FLUSH unless s_valid stays asserted for a new frame in the next cycle, in which case the block SHALL remain in RUN (back-to-back frames, no bubbles).
REQ-026 Accepting s_last with in_cnt!=FFT_LEN-1 SHALL pulse err_len and reset in_cnt to 0.
REQ-027 Accepting a sample with in_cnt=FFT_LEN-1 and s_last=0 SHALL pulse err_len and wrap in_cnt to 0.
REQ-028 In FLUSH, s_ready SHALL be 0, fft_bubble SHALL be 1 and fft_en SHALL be !stall.
REQ-029 FLUSH SHALL move to RUN when the tag register holds no 1 and m_valid=0.
REQ-030 FLUSH SHALL move to RUN after the current enable if s_valid=1 is seen once LAT enables have been issued since the last real sample, without waiting for the full drain.
REQ-031 The out_cnt counter (0..FFT_LEN-1) SHALL increment on m_valid & m_ready and wrap to 0.
REQ-032 m_sof SHALL equal m_valid & (out_cnt==0), and m_eof SHALL equal m_valid & (out_cnt==FFT_LEN-1).
REQ-033 m_idx SHALL be the bit-reverse of out_cnt over IDX_W bits.
REQ-034 If cordic_rdy drops outside WAIT_RDY, the block SHALL force fft_en=0 and s_ready=0 until cordic_rdy returns; state, counters and tags SHALL be held.

Reset
REQ-035 Asserting sys_rst SHALL immediately clear state to WAIT_RDY and clear in_cnt, out_cnt and all tags.
REQ-036 Asserting sys_rst SHALL immediately drive s_ready, fft_en, fft_bubble, m_valid, m_sof, m_eof, err_len and m_idx to 0.
REQ-037 On reset mid-frame, the partial frame SHALL be discarded and no result SHALL be flagged valid until new input arrives.

Verification
REQ-038 Scenario: cordic_rdy=0 for 10 cycles, s_valid=1 -> s_ready=0 and fft_en=0 throughout; s_ready rises 1 cycle after cordic_rdy=1.
REQ-039 Scenario: one 16-sample frame with s_last on sample 15, m_ready=1 -> fft_bubble=1 after sample 15; m_valid asserts LAT enables after the first sample; 16 results with m_idx sequence 0,8,4,12,2,...,15; m_sof on the first result, m_eof on the last.
REQ-040 Scenario: two frames back-to-back -> fft_bubble never asserts between frames; 32 contiguous results; the second m_sof immediately follows the first m_eof.
REQ-041 Scenario: m_ready=0 for 5 cycles mid-output -> fft_en=0 and s_ready=0 for those cycles; m_idx holds; no result is lost or duplicated.
REQ-042 Scenario: s_last on sample 9 -> single err_len pulse; in_cnt=0; the next 16-sample frame processes cleanly.
REQ-043 Scenario: sys_rst pulsed during FLUSH -> all outputs 0 in the same cycle; after release, WAIT_RDY is entered.
